// File: rtl/sid_audio_i2s.sv
// sid_audio_i2s: double-buffered two-channel I2S transmitter for per-SID audio samples
module sid_audio_i2s #(
    parameter int CLK_DIV_HALF = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] audio_i,
    input  logic        audio_ch_i,
    input  logic        audio_stb_i,
    output logic        bck_o,
    output logic        lrck_o,
    output logic        sdata_o,
    output logic        underrun_o,
    output logic        overrun_o
);

    if (SLOT_BITS != 32) begin : g_bad_slot
        $error("sid_audio_i2s: SLOT_BITS must be 32");
    end
    if (CLK_DIV_HALF < 1 || CLK_DIV_HALF > 255) begin : g_bad_div
        $error("sid_audio_i2s: CLK_DIV_HALF must be 1..255");
    end

    logic [7:0]  div;
    logic [5:0]  bit_cnt, bit_nxt;
    logic [19:0] pend_l, pend_r, frame_l, frame_r, nxt_l, nxt_r, word;
    logic [1:0]  fresh, fresh_nxt;
    logic [4:0]  j, idx;
    logic        tc, fall, load, bit_val;

    // Falling-edge/frame-load detection and the serial bit that follows the next falling edge
    always_comb begin
        tc = div == 8'(CLK_DIV_HALF - 1);
        fall = tc && bck_o;
        load = fall && bit_cnt == 6'd63;
        bit_nxt = bit_cnt + 6'd1;
        nxt_l = load ? pend_l : frame_l;
        nxt_r = load ? pend_r : frame_r;
        word = bit_nxt[5] ? nxt_r : nxt_l;
        j = bit_nxt[4:0];
        idx = 5'd20 - j;
        bit_val = (j != 5'd0 && j <= 5'd20) ? word[idx] : 1'b0;
        fresh_nxt[0] = (fresh[0] && !load) || (audio_stb_i && !audio_ch_i);
        fresh_nxt[1] = (fresh[1] && !load) || (audio_stb_i && audio_ch_i);
    end

    // Divider, bit counter, double buffer and status pulses; a strobe in the load cycle lands after the load reads
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            bit_cnt <= '0;
            bck_o <= 1'b0;
            lrck_o <= 1'b0;
            sdata_o <= 1'b0;
            pend_l <= '0;
            pend_r <= '0;
            frame_l <= '0;
            frame_r <= '0;
            fresh <= '0;
            underrun_o <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            div <= tc ? 8'd0 : div + 8'd1;
            if (tc) bck_o <= !bck_o;
            if (fall) begin
                bit_cnt <= bit_nxt;
                lrck_o <= bit_nxt[5];
                sdata_o <= bit_val;
                frame_l <= nxt_l;
                frame_r <= nxt_r;
            end
            if (audio_stb_i && !audio_ch_i) pend_l <= audio_i;
            if (audio_stb_i && audio_ch_i) pend_r <= audio_i;
            fresh <= fresh_nxt;
            underrun_o <= load && fresh != 2'b11;
            overrun_o <= audio_stb_i && fresh[audio_ch_i] && !load;
        end
    end

endmodule

// File: tb/tb_sid_audio_i2s.sv
// tb_sid_audio_i2s: scoreboard bench for the I2S audio transmitter
module tb_sid_audio_i2s;

    logic        clk = 1'b0, rst = 1'b1, stb = 1'b0, ch = 1'b0;
    logic [19:0] aud = '0;
    logic        bck, lrck, sdata, un, ov;
    int          total = 0, bad = 0, un_cnt = 0, ov_cnt = 0;
    logic [39:0] sbq[$];

    typedef struct packed {
        logic [1:0]  nl;
        logic [19:0] l0, l1;
        logic        sr;
        logic [19:0] r;
        logic        sim;
        logic [19:0] rs;
    } step_t;

    step_t steps[7] = '{
        '{2'd1, 20'h80001, 20'h00000, 1'b1, 20'h7FFFE, 1'b0, 20'h00000},
        '{2'd1, 20'h00005, 20'h00000, 1'b0, 20'h00000, 1'b0, 20'h00000},
        '{2'd2, 20'h11111, 20'h22222, 1'b1, 20'h33333, 1'b0, 20'h00000},
        '{2'd1, 20'h44444, 20'h00000, 1'b1, 20'h55555, 1'b1, 20'h66666},
        '{2'd1, 20'h77777, 20'h00000, 1'b0, 20'h00000, 1'b0, 20'h00000},
        '{2'd1, 20'h80000, 20'h00000, 1'b1, 20'h7FFFF, 1'b0, 20'h00000},
        '{2'd0, 20'h00000, 20'h00000, 1'b0, 20'h00000, 1'b0, 20'h00000}
    };

    always #5 clk = ~clk;

    sid_audio_i2s #(.CLK_DIV_HALF(2), .SLOT_BITS(32)) dut (
        .clk(clk), .rst(rst), .audio_i(aud), .audio_ch_i(ch), .audio_stb_i(stb),
        .bck_o(bck), .lrck_o(lrck), .sdata_o(sdata), .underrun_o(un), .overrun_o(ov)
    );

    for (genvar g = 0; g < 2; g++) begin : g_aux
        localparam int D = (g == 0) ? 1 : 4;
        logic a_bck, a_lrck, a_sd, a_un, a_ov;
        int per = 0, frm = 0, bad_t = 0, bad_p = 0;
        sid_audio_i2s #(.CLK_DIV_HALF(D), .SLOT_BITS(32)) u (
            .clk(clk), .rst(rst), .audio_i(aud), .audio_ch_i(ch), .audio_stb_i(stb),
            .bck_o(a_bck), .lrck_o(a_lrck), .sdata_o(a_sd), .underrun_o(a_un), .overrun_o(a_ov)
        );
        initial begin
            int cyc = 0, lf = -1, lr = -1;
            logic bp = 1'b0, lp = 1'b0, sp = 1'b0, f;
            forever begin
                @(negedge clk);
                cyc++;
                if (rst) begin
                    lf = -1;
                    lr = -1;
                end else begin
                    f = bp && !a_bck;
                    if (f) begin
                        if (lf >= 0) begin
                            per = cyc - lf;
                            if (per != 2 * D) bad_p++;
                        end
                        lf = cyc;
                    end
                    if (a_lrck && !lp) begin
                        if (lr >= 0) frm = cyc - lr;
                        lr = cyc;
                    end
                    if ((a_lrck != lp || a_sd != sp) && !f) bad_t++;
                end
                bp = a_bck;
                lp = a_lrck;
                sp = a_sd;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic c, input logic [19:0] v);
        stb = 1'b1;
        ch = c;
        aud = v;
        @(posedge clk);
        #1 stb = 1'b0;
    endtask

    task automatic wait_rise();
        logic lp;
        int n = 0;
        do begin
            lp = lrck;
            @(posedge clk);
            #1;
            n++;
        end while (!(lrck && !lp) && n < 600);
        chk("lrck_rise", 32'(lrck && !lp), 1);
    endtask

    // status pulse counters
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (un) un_cnt++;
            if (ov) ov_cnt++;
        end
    end

    // frame deserialiser: pops one expected L/R pair per completed frame
    initial begin
        logic fr[64];
        logic [5:0] k = '0;
        logic armed = 1'b0, bp = 1'b0, lp = 1'b0, lbad = 1'b0, pad;
        logic [19:0] gl, gr;
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                armed = 1'b0;
            end else if (bp && !bck) begin
                if (lp && !lrck) begin
                    k = '0;
                    armed = 1'b1;
                    lbad = 1'b0;
                end else begin
                    k = k + 6'd1;
                end
                if (armed) begin
                    fr[k] = sdata;
                    if (lrck != k[5]) lbad = 1'b1;
                    if (k == 6'd63) begin
                        pad = 1'b0;
                        for (int i = 0; i < 64; i++)
                            if (i % 32 == 0 || i % 32 > 20) pad = pad | fr[i];
                        for (int i = 0; i < 20; i++) begin
                            gl[19-i] = fr[1+i];
                            gr[19-i] = fr[33+i];
                        end
                        chk("sb_nonempty", 32'(sbq.size() != 0), 1);
                        if (sbq.size() != 0) begin
                            e = sbq.pop_front();
                            chk("frame_l", 32'(gl), 32'(e[39:20]));
                            chk("frame_r", 32'(gr), 32'(e[19:0]));
                        end
                        chk("pad_zero", 32'(pad), 0);
                        chk("lrck_slot", 32'(lbad), 0);
                    end
                end
            end
            bp = bck;
            lp = lrck;
        end
    end

    initial begin
        logic [19:0] el = '0, er = '0;
        logic [1:0] fm = '0;
        logic bp;
        int eun = 0, eov = 0, un0 = 0, ov0 = 0, n, fell_n, used;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(lrck && bck) && n < 1000);
        chk("pre_rst_active", 32'({lrck, bck}), 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_outputs", 32'({bck, lrck, sdata, un, ov}), 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        fell_n = 0;
        bp = bck;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!bck && bp && fell_n == 0) fell_n = n;
            bp = bck;
        end while (!lrck && n < 400);
        chk("first_fall", fell_n, 4);
        chk("first_lrck", n, 128);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                chk("underrun", un_cnt - un0, eun);
                chk("overrun", ov_cnt - ov0, eov);
            end
            un0 = un_cnt;
            ov0 = ov_cnt;
            eov = 0;
            used = 0;
            for (int k = 0; k < steps[i].nl; k++) begin
                if (fm[0]) eov++;
                fm[0] = 1'b1;
                el = (k == 0) ? steps[i].l0 : steps[i].l1;
                strobe(1'b0, el);
                used++;
            end
            if (steps[i].sr) begin
                if (fm[1]) eov++;
                fm[1] = 1'b1;
                er = steps[i].r;
                strobe(1'b1, er);
                used++;
            end
            sbq.push_back({el, er});
            eun = (fm != 2'b11) ? 1 : 0;
            fm = '0;
            if (steps[i].sim) begin
                repeat (127 - used) @(posedge clk);
                #1;
                fm[1] = 1'b1;
                er = steps[i].rs;
                strobe(1'b1, er);
            end
            wait_rise();
        end
        chk("underrun", un_cnt - un0, eun);
        chk("overrun", ov_cnt - ov0, eov);
        n = 0;
        while (sbq.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("sb_drained", sbq.size(), 0);
        chk("div1_bck_period", g_aux[0].per, 2);
        chk("div1_frame", g_aux[0].frm, 128);
        chk("div1_edge_errs", g_aux[0].bad_t + g_aux[0].bad_p, 0);
        chk("div4_bck_period", g_aux[1].per, 8);
        chk("div4_frame", g_aux[1].frm, 512);
        chk("div4_edge_errs", g_aux[1].bad_t + g_aux[1].bad_p, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
